// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - request/grant and memory strobe bundle for the shared memory port
interface mem_port_arbiter_if;
    logic [2:0] req;
    logic [2:0] we;
    logic [2:0] gnt;
    logic [2:0] done;
    logic [1:0] sel;
    logic       mem_en;
    logic       mem_we;
    logic       busy;

    modport master (
        output req, we,
        input  gnt, done, sel, mem_en, mem_we, busy
    );

    modport slave (
        input  req, we,
        output gnt, done, sel, mem_en, mem_we, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter and fixed-latency sequencer for the shared memory port
module mem_port_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [3:0] CNT_INIT = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;

    state_t     state;
    logic [1:0] last;
    logic [3:0] cnt;
    logic [2:0] gnt_q;
    logic [2:0] done_q;
    logic [1:0] sel_q;
    logic       mem_en_q;
    logic       mem_we_q;
    logic       busy_q;

    logic [1:0] win;
    logic [2:0] win_oh;

    // Search starts one past the last winner; only meaningful when some req bit is set.
    function automatic logic [1:0] pick(input logic [1:0] ptr, input logic [2:0] r);
        logic [1:0] w;
        w = 2'd0;
        case (ptr)
            2'd0:    w = r[1] ? 2'd1 : (r[2] ? 2'd2 : 2'd0);
            2'd1:    w = r[2] ? 2'd2 : (r[0] ? 2'd0 : 2'd1);
            default: w = r[0] ? 2'd0 : (r[1] ? 2'd1 : 2'd2);
        endcase
        return w;
    endfunction

    assign win    = pick(last, bus.req);
    assign win_oh = 3'b001 << win;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            last     <= 2'd2;
            cnt      <= 4'd0;
            gnt_q    <= 3'b000;
            done_q   <= 3'b000;
            sel_q    <= 2'b11;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        state    <= ACCESS;
                        gnt_q    <= win_oh;
                        sel_q    <= win;
                        mem_en_q <= 1'b1;
                        mem_we_q <= |(bus.we & win_oh);
                        busy_q   <= 1'b1;
                    end
                end
                ACCESS: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    if (MEM_LAT > 1) begin
                        state <= WAIT;
                        cnt   <= CNT_INIT;
                    end else begin
                        state  <= RESP;
                        done_q <= gnt_q;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state  <= RESP;
                        done_q <= gnt_q;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    last   <= sel_q;
                    done_q <= 3'b000;
                    gnt_q  <= 3'b000;
                    sel_q  <= 2'b11;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.done   = done_q;
    assign bus.sel    = sel_q;
    assign bus.mem_en = mem_en_q;
    assign bus.mem_we = mem_we_q;
    assign bus.busy   = busy_q;

endmodule
